// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/load writeback arbiter, registered regfile write port, optional pending-write scoreboard (REGFILE_SCOREBOARD_EN); ports: clk, rst_n, alu_*/mem_* requests, reg_write/write_reg/write_data, issue_valid/issue_rd/rs1/rs2, rs1_busy/rs2_busy/stall
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall
);
  localparam int NREG = 2 ** ADDR_W;
  logic              last_alu;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  assign alu_ready = rst_n & alu_valid & (~mem_valid | ~last_alu);
  assign mem_ready = rst_n & mem_valid & (~alu_valid | last_alu);
  assign xfer      = alu_ready | mem_ready;
  assign sel_rd    = alu_ready ? alu_rd : mem_rd;
  assign sel_data  = alu_ready ? alu_data : mem_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_alu   <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      last_alu  <= xfer ? alu_ready : last_alu;
      reg_write <= xfer && (sel_rd != '0);
      if (xfer) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;
  logic            issue_ok;
  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign stall    = issue_valid & (rs1_busy | rs2_busy | busy[issue_rd]);
  assign issue_ok = issue_valid & ~stall & (issue_rd != '0);
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[issue_rd]  = issue_ok;
    clr_m[write_reg] = reg_write;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~clr_m) | set_m;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rd, rs1, rs2, NREG[0]};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
  assign stall     = 1'b0;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, writeback data width.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / ADDR_W / DATA_W  ALU writeback request.
REQ-006 alu_ready  output  1  ALU request accepted this cycle.
REQ-007 mem_valid / mem_rd / mem_data  input  1 / ADDR_W / DATA_W  load-unit writeback request.
REQ-008 mem_ready  output  1  load request accepted this cycle.
REQ-009 reg_write / write_reg / write_data  output  1 / ADDR_W / DATA_W  register-file write port, registered.
REQ-010 issue_valid / issue_rd  input  1 / ADDR_W  instruction issue; rd to be marked pending.
REQ-011 rs1 / rs2  input  ADDR_W each  source indices of the issuing instruction.
REQ-012 rs1_busy / rs2_busy / stall  output  1 each  pending-write flags and issue stall.

Function
REQ-013 Transfer on a requester SHALL occur in a cycle where its valid and ready are both 1; requesters hold rd/data stable while valid and not ready.
REQ-014 ready SHALL be combinational: at most one of alu_ready/mem_ready is 1 per cycle; ready is 1 only to a valid requester.
REQ-015 Single valid requester SHALL be granted the same cycle.
REQ-016 Both valid: grant SHALL go to the requester not granted most recently (round-robin); last-grant pointer updates only on a transfer.
REQ-017 One cycle after a transfer, reg_write SHALL be 1 with write_reg/write_data equal to the transferred rd/data; otherwise reg_write 0 and write_reg/write_data hold their previous values.
REQ-018 A transfer with rd == 0 SHALL be accepted but produce reg_write = 0 the next cycle.
REQ-019 Throughput SHALL be one transfer per cycle; back-to-back transfers yield back-to-back writes.
REQ-020 busy[i] SHALL set at the edge where issue_valid=1, stall=0, issue_rd=i, i != 0.
REQ-021 busy[i] SHALL clear at the edge where reg_write=1 and write_reg=i.
REQ-022 Set and clear of the same index at the same edge: set SHALL win.
REQ-023 busy[0] SHALL be constant 0.
REQ-024 rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational.
REQ-025 stall SHALL equal issue_valid AND (rs1_busy OR rs2_busy OR busy[issue_rd]); a stalled issue changes no state.

Reset
REQ-026 rst_n low SHALL immediately force reg_write=0, write_reg=0, write_data=0, all busy bits 0, last-grant pointer = mem (ALU wins first tie).
REQ-027 Reset mid-operation SHALL discard any accepted-but-uncommitted write (no reg_write after release).
REQ-028 alu_ready/mem_ready SHALL be 0 while rst_n is low.

Configuration
REQ-029 Macro REGFILE_SCOREBOARD_EN defined: scoreboard per REQ-020..REQ-025 present.
REQ-030 Macro REGFILE_SCOREBOARD_EN undefined: no busy storage; rs1_busy, rs2_busy, stall constant 0; arbiter unchanged.

Verification
REQ-031 alu_valid=1 rd=3 data=0xDEADBEEF alone -> alu_ready=1 same cycle; next cycle reg_write=1, write_reg=3, write_data=0xDEADBEEF.
REQ-032 Both valid for 4 cycles after reset (alu rd=1, mem rd=2) -> grants ALU, MEM, ALU, MEM; write_reg sequence 1,2,1,2.
REQ-033 mem_valid rd=0 data=0x55 -> mem_ready=1; next cycle reg_write=0.
REQ-034 Issue rd=5; next issue with rs1=5 -> stall=1, rs1_busy=1; ALU writes rd=5 -> stall=0 the cycle after reg_write commit.
REQ-035 reg_write to rd=7 at same edge as issue rd=7 -> busy[7]=1 after edge.
REQ-036 Assert rst_n=0 the cycle after a transfer -> reg_write stays 0, all busy 0, next tie grants ALU.
